// File: rtl/lcd_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_spi_receiver
// Brief    : Display-side endpoint of a 4-wire LCD SPI link. Oversamples
//            sclk/mosi/cs/dc on the system clock, deserialises MSB-first
//            bytes tagged with dc, decodes the CASET/RASET/RAMWR/DISPON/
//            DISPOFF command subset and emits RGB565 pixels with x/y.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_receiver #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst,
    input  logic        lcd_sclk,
    input  logic        lcd_mosi,
    input  logic        lcd_cs,
    input  logic        lcd_dc,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        frame_done,
    output logic        disp_on
);

    // Decoder states
    localparam logic [2:0] c_CMD_WAIT = 3'd0;
    localparam logic [2:0] c_CASET_P  = 3'd1;
    localparam logic [2:0] c_RASET_P  = 3'd2;
    localparam logic [2:0] c_RAMWR_D  = 3'd3;
    localparam logic [2:0] c_SKIP     = 3'd4;

    // Command opcodes
    localparam logic [7:0] c_OP_CASET   = 8'h2A;
    localparam logic [7:0] c_OP_RASET   = 8'h2B;
    localparam logic [7:0] c_OP_RAMWR   = 8'h2C;
    localparam logic [7:0] c_OP_DISPON  = 8'h29;
    localparam logic [7:0] c_OP_DISPOFF = 8'h28;

    // Last valid column / row, used as the window clamp limits
    localparam logic [8:0] c_X_LAST = 9'(H_RES - 1);
    localparam logic [8:0] c_Y_LAST = 9'(V_RES - 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic r_sclk_m, r_sclk_s, r_sclk_d;
    logic r_mosi_m, r_mosi_s;
    logic r_cs_m,   r_cs_s;
    logic r_dc_m,   r_dc_s;
    logic w_sclk_rise;

    // Two-flop synchronisers plus a delayed sclk copy for edge detection
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            r_sclk_m <= 1'b0;
            r_sclk_s <= 1'b0;
            r_sclk_d <= 1'b0;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
            r_cs_m   <= 1'b1;
            r_cs_s   <= 1'b1;
            r_dc_m   <= 1'b0;
            r_dc_s   <= 1'b0;
        end else begin
            r_sclk_m <= lcd_sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_d <= r_sclk_s;
            r_mosi_m <= lcd_mosi;
            r_mosi_s <= r_mosi_m;
            r_cs_m   <= lcd_cs;
            r_cs_s   <= r_cs_m;
            r_dc_m   <= lcd_dc;
            r_dc_s   <= r_dc_m;
        end
    end

    assign w_sclk_rise = r_sclk_s & ~r_sclk_d;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_byte_pend;

    // Shift in one bit per sclk rise; a deselect throws away a partial byte
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_byte_pend <= 1'b0;
            byte_data   <= 8'd0;
            byte_dc     <= 1'b0;
        end else begin
            r_byte_pend <= 1'b0;
            if (r_cs_s) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 7'd0;
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[5:0], r_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_data   <= {r_shift, r_mosi_s};
                    byte_dc     <= r_dc_s;
                    r_byte_pend <= 1'b1;
                end
            end
        end
    end

    // Byte strobes; byte_dc already holds the new byte's tag here
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            byte_valid <= 1'b0;
            cmd_valid  <= 1'b0;
        end else begin
            byte_valid <= r_byte_pend;
            cmd_valid  <= r_byte_pend & ~byte_dc;
        end
    end

    // ------------------------------------------------------------------
    // Command decoder
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_cmd_byte;
    logic       w_data_byte;
    logic [1:0] r_pidx;
    logic       r_sh_lsb;
    logic [7:0] r_sl;
    logic       r_eh_lsb;
    logic [8:0] r_xs, r_xe, r_ys, r_ye;
    logic [8:0] r_cx, r_cy;
    logic       r_phase;
    logic [7:0] r_hi;
    logic [8:0] w_start_raw, w_end_raw, w_limit, w_end_clamp, w_start_clamp;

    assign w_cmd_byte  = byte_valid & ~byte_dc;
    assign w_data_byte = byte_valid &  byte_dc;

    // Window commit: clamp the end to the panel, then the start to the end
    assign w_start_raw   = {r_sh_lsb, r_sl};
    assign w_end_raw     = {r_eh_lsb, byte_data};
    assign w_limit       = (r_state == c_RASET_P) ? c_Y_LAST : c_X_LAST;
    assign w_end_clamp   = (w_end_raw > w_limit) ? w_limit : w_end_raw;
    assign w_start_clamp = (w_start_raw > w_end_clamp) ? w_end_clamp : w_start_raw;

    // Decoder state register
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            r_state <= c_CMD_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: commands dispatch from any state, parameters end on byte 4
    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_byte) begin
            case (byte_data)
                c_OP_CASET:   w_state_nxt = c_CASET_P;
                c_OP_RASET:   w_state_nxt = c_RASET_P;
                c_OP_RAMWR:   w_state_nxt = c_RAMWR_D;
                c_OP_DISPON:  w_state_nxt = c_CMD_WAIT;
                c_OP_DISPOFF: w_state_nxt = c_CMD_WAIT;
                default:      w_state_nxt = c_SKIP;
            endcase
        end else if (w_data_byte) begin
            case (r_state)
                c_CASET_P, c_RASET_P: begin
                    if (r_pidx == 2'd3) begin
                        w_state_nxt = c_CMD_WAIT;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Parameter capture, window commit, display status and pixel cursor
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            r_pidx      <= 2'd0;
            r_sh_lsb    <= 1'b0;
            r_sl        <= 8'd0;
            r_eh_lsb    <= 1'b0;
            r_xs        <= 9'd0;
            r_xe        <= c_X_LAST;
            r_ys        <= 9'd0;
            r_ye        <= c_Y_LAST;
            r_cx        <= 9'd0;
            r_cy        <= 9'd0;
            r_phase     <= 1'b0;
            r_hi        <= 8'd0;
            disp_on     <= 1'b0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pixel_data  <= 16'd0;
            pixel_x     <= 9'd0;
            pixel_y     <= 9'd0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (w_cmd_byte) begin
                // Any command drops shadow parameters and a pending odd byte
                r_pidx  <= 2'd0;
                r_phase <= 1'b0;
                case (byte_data)
                    c_OP_RAMWR: begin
                        r_cx <= r_xs;
                        r_cy <= r_ys;
                    end
                    c_OP_DISPON:  disp_on <= 1'b1;
                    c_OP_DISPOFF: disp_on <= 1'b0;
                    default: ;
                endcase
            end else if (w_data_byte) begin
                case (r_state)
                    c_CASET_P, c_RASET_P: begin
                        r_pidx <= r_pidx + 2'd1;
                        case (r_pidx)
                            2'd0: r_sh_lsb <= byte_data[0];
                            2'd1: r_sl     <= byte_data;
                            2'd2: r_eh_lsb <= byte_data[0];
                            default: begin
                                if (r_state == c_CASET_P) begin
                                    r_xs <= w_start_clamp;
                                    r_xe <= w_end_clamp;
                                end else begin
                                    r_ys <= w_start_clamp;
                                    r_ye <= w_end_clamp;
                                end
                            end
                        endcase
                    end
                    c_RAMWR_D: begin
                        if (!r_phase) begin
                            r_hi    <= byte_data;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase     <= 1'b0;
                            pixel_valid <= 1'b1;
                            pixel_data  <= {r_hi, byte_data};
                            pixel_x     <= r_cx;
                            pixel_y     <= r_cy;
                            if (r_cx == r_xe) begin
                                r_cx <= r_xs;
                                if (r_cy == r_ye) begin
                                    frame_done <= 1'b1;
                                    r_cy       <= r_ys;
                                end else begin
                                    r_cy <= r_cy + 9'd1;
                                end
                            end else begin
                                r_cx <= r_cx + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_receiver
// Brief    : Scoreboard bench for lcd_spi_receiver. A byte-level reference
//            model predicts bytes and pixels as stimulus is issued; a monitor
//            pops and compares whenever the DUT strobes an output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_receiver;
    localparam int H_RES = 240;
    localparam int V_RES = 320;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, mosi, cs, dc;
    logic        byte_valid, byte_dc, cmd_valid, pixel_valid, frame_done, disp_on;
    logic [7:0]  byte_data;
    logic [15:0] pixel_data;
    logic [8:0]  pixel_x, pixel_y;

    always #10 clk = ~clk;

    lcd_spi_receiver #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .sys_clk_50MHz (clk),
        .sys_rst       (rst),
        .lcd_sclk      (sclk),
        .lcd_mosi      (mosi),
        .lcd_cs        (cs),
        .lcd_dc        (dc),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_dc       (byte_dc),
        .cmd_valid     (cmd_valid),
        .pixel_valid   (pixel_valid),
        .pixel_data    (pixel_data),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .frame_done    (frame_done),
        .disp_on       (disp_on)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Expected byte: {cmd_valid, dc, data}; expected pixel: {frame_done, x, y, data}
    logic [9:0]  exp_bytes[$];
    logic [34:0] exp_pix[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (panel command semantics) ----------
    int m_st;       // 0 idle, 1 column params, 2 row params, 3 pixel stream, 4 ignore
    int m_idx, m_ph, m_hi, m_disp;
    int m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
    int m_prm[4];

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_ph = 0; m_hi = 0; m_disp = 0;
        m_xs = 0; m_xe = H_RES - 1; m_ys = 0; m_ye = V_RES - 1;
        m_cx = 0; m_cy = 0;
        exp_bytes.delete();
        exp_pix.delete();
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        int s, e, lim;
        logic fd;
        exp_bytes.push_back({~d, d, b});
        if (!d) begin
            m_idx = 0;
            m_ph  = 0;
            case (b)
                8'h2A: m_st = 1;
                8'h2B: m_st = 2;
                8'h2C: begin m_st = 3; m_cx = m_xs; m_cy = m_ys; end
                8'h29: begin m_st = 0; m_disp = 1; end
                8'h28: begin m_st = 0; m_disp = 0; end
                default: m_st = 4;
            endcase
        end else if (m_st == 1 || m_st == 2) begin
            m_prm[m_idx] = int'(b);
            m_idx++;
            if (m_idx == 4) begin
                s   = (m_prm[0] * 256 + m_prm[1]) % 512;
                e   = (m_prm[2] * 256 + m_prm[3]) % 512;
                lim = (m_st == 1) ? H_RES : V_RES;
                if (e > lim - 1) e = lim - 1;
                if (s > e) s = e;
                if (m_st == 1) begin m_xs = s; m_xe = e; end
                else           begin m_ys = s; m_ye = e; end
                m_st = 0;
            end
        end else if (m_st == 3) begin
            if (m_ph == 0) begin
                m_hi = int'(b);
                m_ph = 1;
            end else begin
                m_ph = 0;
                fd = (m_cx == m_xe) && (m_cy == m_ye);
                exp_pix.push_back({fd, 9'(m_cx), 9'(m_cy), 8'(m_hi), b});
                if (fd) begin
                    m_cx = m_xs; m_cy = m_ys;
                end else if (m_cx == m_xe) begin
                    m_cx = m_xs; m_cy = m_cy + 1;
                end else begin
                    m_cx = m_cx + 1;
                end
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [9:0]  eb;
    logic [34:0] ep;

    // Compare every strobe against the head of the matching expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                if (exp_bytes.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL byte_unexpected: got byte 0x%0h dc=%0b, expected none", byte_data, byte_dc);
                end else begin
                    eb = exp_bytes.pop_front();
                    chk("byte_data", 32'(byte_data), 32'(eb[7:0]));
                    chk("byte_dc",   32'(byte_dc),   32'(eb[8]));
                    chk("cmd_valid", 32'(cmd_valid), 32'(eb[9]));
                end
            end else if (cmd_valid) begin
                n_vec++; n_fail++;
                $display("FAIL cmd_valid_alone: got cmd_valid=1 without byte_valid, expected 0");
            end
            if (pixel_valid) begin
                if (exp_pix.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL pixel_unexpected: got (%0d,%0d)=0x%0h, expected none", pixel_x, pixel_y, pixel_data);
                end else begin
                    ep = exp_pix.pop_front();
                    chk("pixel_x",    32'(pixel_x),    32'(ep[33:25]));
                    chk("pixel_y",    32'(pixel_y),    32'(ep[24:16]));
                    chk("pixel_data", 32'(pixel_data), 32'(ep[15:0]));
                    chk("frame_done", 32'(frame_done), 32'(ep[34]));
                end
            end else if (frame_done) begin
                n_vec++; n_fail++;
                $display("FAIL frame_done_alone: got frame_done=1 without pixel_valid, expected 0");
            end
        end
    end

    // ---------------- SPI driver ----------------
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input logic d);
        mosi = b; dc = d;
        wclk(3);
        sclk = 1'b1;
        wclk(3);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        model_byte(d, b);
        cs = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic send_dat(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    task automatic send_window(input logic [7:0] op, input int s, input int e);
        send_cmd(op);
        send_dat(8'(s >> 8)); send_dat(8'(s));
        send_dat(8'(e >> 8)); send_dat(8'(e));
    endtask

    // Wait (bounded) for all expectations to be consumed, then check status
    task automatic drain(input string tag);
        int k;
        wclk(8);
        cs = 1'b1;
        k = 0;
        while ((exp_bytes.size() != 0 || exp_pix.size() != 0) && k < 60) begin
            wclk(1); k++;
        end
        wclk(4);
        chk({tag, "_bytes_left"},  32'(exp_bytes.size()), 32'd0);
        chk({tag, "_pixels_left"}, 32'(exp_pix.size()),   32'd0);
        chk({tag, "_disp_on"},     32'(disp_on),          32'(m_disp));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_valid"},  32'(byte_valid),  32'd0);
        chk({tag, "_cmd_valid"},   32'(cmd_valid),   32'd0);
        chk({tag, "_byte_data"},   32'({byte_dc, byte_data}), 32'd0);
        chk({tag, "_pixel_valid"}, 32'({pixel_valid, frame_done}), 32'd0);
        chk({tag, "_pixel_data"},  32'(pixel_data),  32'd0);
        chk({tag, "_pixel_xy"},    32'({pixel_x, pixel_y}), 32'd0);
        chk({tag, "_disp_on"},     32'(disp_on),     32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0;
        model_reset();
        wclk(3);
        @(negedge clk);
        rst = 1'b0;
        wclk(4);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1800000;
        $display("FAIL watchdog: simulation exceeded time budget, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, n;
        logic [7:0] b;

        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");

        // Two pixels at the origin after reset
        send_cmd(8'h2C);
        send_dat(8'hF8); send_dat(8'h00); send_dat(8'h07); send_dat(8'hE0);
        drain("t1");

        // 10x2 window, frame_done on its last pixel
        do_reset();
        send_window(8'h2A, 10, 19);
        send_window(8'h2B, 5, 6);
        send_cmd(8'h2C);
        for (int i = 0; i < 40; i++) send_dat(8'($urandom));
        drain("t2");

        // Partial byte discarded by deselect
        do_reset();
        cs = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b1);
        wclk(3);
        cs = 1'b1;
        wclk(6);
        send_dat(8'hA5);
        drain("t3");

        // Column window beyond the panel collapses to the last column
        do_reset();
        send_window(8'h2A, 240, 256);
        send_cmd(8'h2C);
        for (int i = 0; i < 8; i++) send_dat(8'($urandom));
        drain("t4");

        // Aborted CASET leaves the window alone; display on
        do_reset();
        send_cmd(8'h2A); send_dat(8'h00); send_dat(8'h05);
        send_cmd(8'h29);
        send_cmd(8'h2C);
        send_dat(8'h12); send_dat(8'h34);
        drain("t5");

        // Odd byte dropped by DISPOFF, then reset mid-byte
        send_cmd(8'h2C);
        send_dat(8'hAB); send_dat(8'hCD); send_dat(8'hEF);
        send_cmd(8'h28);
        drain("t6");
        cs = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        wclk(4);
        send_dat(8'h5A);
        drain("t6b");

        // Randomised command/data mix
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: begin
                    n = $urandom_range(0, 250);
                    send_window(8'h2A, n, n + $urandom_range(0, 3));
                end
                1: begin
                    n = $urandom_range(0, 330);
                    send_window(8'h2B, n, n + $urandom_range(0, 2));
                end
                2: begin
                    send_cmd(8'h2C);
                    n = $urandom_range(2, 13);
                    for (int i = 0; i < n; i++) send_dat(8'($urandom));
                end
                3: send_cmd($urandom_range(0, 1) ? 8'h29 : 8'h28);
                4: begin
                    b = 8'($urandom_range(0, 8'h27));
                    send_cmd(b);
                    n = $urandom_range(0, 2);
                    for (int i = 0; i < n; i++) send_dat(8'($urandom));
                end
                default: begin
                    send_cmd($urandom_range(0, 1) ? 8'h2A : 8'h2B);
                    n = $urandom_range(0, 3);
                    for (int i = 0; i < n; i++) send_dat(8'($urandom));
                end
            endcase
        end
        send_cmd(8'h2C);
        for (int i = 0; i < 12; i++) send_dat(8'($urandom));
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
